// File: rtl/kbd_decode.sv
// kbd_decode: PS/2 set-2 byte parser with modifier tracking and a show-ahead event FIFO.
// Optional KBD_ASCII_EN adds a key_ascii lookup of the FIFO head.
module kbd_decode #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scode,
  input  logic       scode_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] mod_state,
  output logic       ovf,
  output logic       seq_err
`ifdef KBD_ASCII_EN
  ,
  output logic [7:0] key_ascii
`endif
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
`ifdef KBD_ASCII_EN
  localparam int EW = 11;
`else
  localparam int EW = 10;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_E1} state_t;

  state_t      state;
  logic [2:0]  skip;
  logic [31:0] timer;
  logic        vld_p0;
  logic [7:0]  code_p0;
  logic        ext_p0;
  logic        brk_p0;
`ifdef KBD_ASCII_EN
  logic        shift_p0;
`endif

  // Modifier bits are {alt, ctrl, rshift, lshift}; make sets, break clears.
  function automatic logic [3:0] mod_next(input logic [3:0] m, input logic [7:0] c,
                                          input logic ext, input logic brk);
    logic [3:0] r;
    r = m;
    if (c == 8'h12 && !ext) r[0] = !brk;
    if (c == 8'h59 && !ext) r[1] = !brk;
    if (c == 8'h14)         r[2] = !brk;
    if (c == 8'h11)         r[3] = !brk;
    return r;
  endfunction

  // ---- stage p0: byte decode, prefix FSM, modifiers, timeout ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      skip      <= 3'd0;
      timer     <= 32'd0;
      vld_p0    <= 1'b0;
      seq_err   <= 1'b0;
      mod_state <= 4'h0;
    end else begin
      vld_p0  <= 1'b0;
      seq_err <= 1'b0;
      if (scode_en) begin
        timer <= 32'd0;
        case (state)
          ST_IDLE: begin
            case (scode)
              8'hE0: state <= ST_E0;
              8'hF0: state <= ST_F0;
              8'hE1: begin
                state <= ST_E1;
                skip  <= 3'd7;
              end
              8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
              end
              8'h00, 8'hFF: seq_err <= 1'b1;
              default: begin
                vld_p0    <= 1'b1;
                mod_state <= mod_next(mod_state, scode, 1'b0, 1'b0);
              end
            endcase
          end
          ST_E0: begin
            if (scode == 8'hF0) begin
              state <= ST_E0F0;
            end else begin
              state <= ST_IDLE;
              // E0 12 is the keyboard's fake shift around extended keys
              if (scode != 8'h12) begin
                vld_p0    <= 1'b1;
                mod_state <= mod_next(mod_state, scode, 1'b1, 1'b0);
              end
            end
          end
          ST_F0: begin
            state     <= ST_IDLE;
            vld_p0    <= 1'b1;
            mod_state <= mod_next(mod_state, scode, 1'b0, 1'b1);
          end
          ST_E0F0: begin
            state <= ST_IDLE;
            if (scode != 8'h12) begin
              vld_p0    <= 1'b1;
              mod_state <= mod_next(mod_state, scode, 1'b1, 1'b1);
            end
          end
          ST_E1: begin
            skip <= skip - 3'd1;
            if (skip == 3'd1) begin
              state  <= ST_IDLE;
              vld_p0 <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (timer == TO_LAST) begin
          seq_err <= 1'b1;
          state   <= ST_IDLE;
          skip    <= 3'd0;
          timer   <= 32'd0;
        end else begin
          timer <= timer + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (scode_en) begin
      code_p0  <= (state == ST_E1) ? 8'hE1 : scode;
      ext_p0   <= (state == ST_E0) || (state == ST_E0F0);
      brk_p0   <= (state == ST_F0) || (state == ST_E0F0);
`ifdef KBD_ASCII_EN
      shift_p0 <= mod_state[0] | mod_state[1];
`endif
    end
  end

  // ---- stage p1: event FIFO write / show-ahead read ----
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] entry_p0;
  logic [EW-1:0] head;
  logic          full;
  logic          pop;
  logic          wr_ok;

`ifdef KBD_ASCII_EN
  assign entry_p0 = {shift_p0, ext_p0, brk_p0, code_p0};
`else
  assign entry_p0 = {ext_p0, brk_p0, code_p0};
`endif

  assign full      = (count == FULL_CNT);
  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;
  // a full FIFO still takes the write when the head leaves in the same cycle
  assign wr_ok     = vld_p0 & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= entry_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= vld_p0 & full & ~pop;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign key_code = key_valid ? head[7:0] : 8'h00;
  assign key_brk  = key_valid & head[8];
  assign key_ext  = key_valid & head[9];

`ifdef KBD_ASCII_EN
  // Returns {shifted, plain} pairs; 0 for anything without a printable mapping.
  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic sh);
    logic [15:0] p;
    case (c)
      8'h1C: p = {"A", "a"};  8'h32: p = {"B", "b"};  8'h21: p = {"C", "c"};
      8'h23: p = {"D", "d"};  8'h24: p = {"E", "e"};  8'h2B: p = {"F", "f"};
      8'h34: p = {"G", "g"};  8'h33: p = {"H", "h"};  8'h43: p = {"I", "i"};
      8'h3B: p = {"J", "j"};  8'h42: p = {"K", "k"};  8'h4B: p = {"L", "l"};
      8'h3A: p = {"M", "m"};  8'h31: p = {"N", "n"};  8'h44: p = {"O", "o"};
      8'h4D: p = {"P", "p"};  8'h15: p = {"Q", "q"};  8'h2D: p = {"R", "r"};
      8'h1B: p = {"S", "s"};  8'h2C: p = {"T", "t"};  8'h3C: p = {"U", "u"};
      8'h2A: p = {"V", "v"};  8'h1D: p = {"W", "w"};  8'h22: p = {"X", "x"};
      8'h35: p = {"Y", "y"};  8'h1A: p = {"Z", "z"};
      8'h16: p = {"!", "1"};  8'h1E: p = {"@", "2"};  8'h26: p = {"#", "3"};
      8'h25: p = {"$", "4"};  8'h2E: p = {"%", "5"};  8'h36: p = {"^", "6"};
      8'h3D: p = {"&", "7"};  8'h3E: p = {"*", "8"};  8'h46: p = {"(", "9"};
      8'h45: p = {")", "0"};
      8'h29: p = {" ", " "};  8'h5A: p = 16'h0D0D;    8'h66: p = 16'h0808;
      8'h4E: p = {"_", "-"};  8'h55: p = {"+", "="};  8'h41: p = {"<", ","};
      8'h49: p = {">", "."};  8'h4A: p = {"?", "/"};  8'h4C: p = {":", ";"};
      8'h52: p = {"\"", "'"}; 8'h54: p = {"{", "["};  8'h5B: p = {"}", "]"};
      8'h5D: p = {"|", "\\"}; 8'h0E: p = {"~", 8'h60};
      default: p = 16'h0000;
    endcase
    return sh ? p[15:8] : p[7:0];
  endfunction

  assign key_ascii = (key_valid && !head[9] && !head[8]) ? ascii_of(head[7:0], head[10]) : 8'h00;
`endif

endmodule

// File: tb/tb_kbd_decode.sv
// Scoreboard bench for kbd_decode: directed PS/2 sequences plus randomized byte streams
// checked against a prefix-buffer reference model.
`timescale 1ns/1ps
module tb_kbd_decode;
  localparam int DEPTH = 4;
  localparam int TO    = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scode;
  logic       scode_en;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       key_valid;
  logic [3:0] mod_state;
  logic       ovf;
  logic       seq_err;
`ifdef KBD_ASCII_EN
  logic [7:0] key_ascii;
`endif

  always #5 clk = ~clk;

  kbd_decode #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .scode(scode), .scode_en(scode_en),
    .key_code(key_code), .key_ext(key_ext), .key_brk(key_brk),
    .key_valid(key_valid), .key_ready(key_ready), .mod_state(mod_state),
    .ovf(ovf), .seq_err(seq_err)
`ifdef KBD_ASCII_EN
    , .key_ascii(key_ascii)
`endif
  );

  typedef struct packed { logic [7:0] code; logic ext; logic brk; } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] seq[$];
  logic [3:0] m_mods;
  int         m_occ, m_drops, m_errs, m_idle;
  bit         m_wr_pend;
  ev_t        m_pend_ev;
  bit         last_en;
  int         seen_ovf = 0, seen_err = 0, n_pop = 0;
  int         n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: buffer prefix bytes; the first non-prefix byte closes a sequence,
  // with ext/brk given by which prefixes were buffered. E1 swallows 7 more bytes.
  task automatic m_byte(input logic [7:0] b);
    bit ext, brk;
    m_idle = 0;
    if (seq.size() > 0 && seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) begin
        seq.delete();
        m_wr_pend = 1; m_pend_ev = {8'hE1, 1'b0, 1'b0};
      end
      return;
    end
    if (seq.size() == 0) begin
      if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) return;
      if (b == 8'h00 || b == 8'hFF) begin m_errs++; return; end
      if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin seq.push_back(b); return; end
    end else if (b == 8'hF0 && seq.size() == 1 && seq[0] == 8'hE0) begin
      seq.push_back(b);
      return;
    end
    ext = 0; brk = 0;
    foreach (seq[i]) begin
      if (seq[i] == 8'hE0) ext = 1;
      if (seq[i] == 8'hF0) brk = 1;
    end
    seq.delete();
    if (ext && b == 8'h12) return;
    if (b == 8'h12 && !ext) m_mods[0] = !brk;
    if (b == 8'h59 && !ext) m_mods[1] = !brk;
    if (b == 8'h14) m_mods[2] = !brk;
    if (b == 8'h11) m_mods[3] = !brk;
    m_wr_pend = 1; m_pend_ev = {b, ext, brk};
  endtask

  // One clock: drive inputs for the coming edge and advance the model past it.
  task automatic step(input bit en, input logic [7:0] b, input bit rdy);
    bit pop;
    @(posedge clk); #2;
    if (last_en) chk("mod_state", 32'(mod_state), 32'(m_mods));
    scode_en = en; scode = b; key_ready = rdy; last_en = en;
    pop = (m_occ > 0) && rdy;
    if (m_wr_pend) begin
      if (m_occ == DEPTH && !pop) m_drops++;
      else begin exp_q.push_back(m_pend_ev); m_occ++; end
      m_wr_pend = 0;
    end
    if (pop) m_occ--;
    if (en) m_byte(b);
    else if (seq.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin m_idle = 0; seq.delete(); m_errs++; end
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    scode_en = 0; scode = 0; key_ready = 0;
    rst = 1; #1;
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_mod_state", 32'(mod_state), 32'd0);
    chk("rst_ovf_err", 32'({ovf, seq_err}), 32'd0);
    exp_q.delete(); seq.delete();
    m_mods = 0; m_occ = 0; m_idle = 0; m_wr_pend = 0; last_en = 0;
    @(posedge clk); #2;
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ovf) seen_ovf++;
      if (seq_err) seen_err++;
      if (key_valid && key_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: got %h/%b/%b expected none", key_code, key_ext, key_brk);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("event", 32'({key_code, key_ext, key_brk}), 32'(mon_ev));
        end
      end
    end
  end

  function automatic logic [7:0] pick_byte();
    int r;
    logic [7:0] keys [8];
    keys = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'h5A, 8'h29, 8'h66, 8'h4A};
    r = $urandom_range(0, 19);
    case (r)
      0, 1:   return 8'hE0;
      2, 3:   return 8'hF0;
      4:      return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
      5:      return 8'h12;
      6:      return 8'h59;
      7:      return 8'h14;
      8:      return 8'h11;
      9:      return ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
      10:     return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
      11:     return 8'($urandom_range(0, 255));
      default: return keys[$urandom_range(0, 7)];
    endcase
  endfunction

  int o0, e0, p0;

  initial begin
    rst = 0; scode = 0; scode_en = 0; key_ready = 0;
    m_mods = 0; m_occ = 0; m_drops = 0; m_errs = 0; m_idle = 0; m_wr_pend = 0; last_en = 0;
    #1;
    do_reset();

    // two-clock latency for a plain make
    step(1'b1, 8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("latency_k", 32'(key_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("latency_k1", 32'(key_valid), 32'd1);
    chk("latency_code", 32'({key_code, key_ext, key_brk}), 32'({8'h1C, 2'b00}));
    idle(3, 1'b1);

    // extended break, plain break
    p0 = n_pop;
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hF0); send(8'h1C);
    idle(4, 1'b1);
    chk("prefix_events", 32'(n_pop - p0), 32'd2);

    // shift tracking
    send(8'h12); idle(1, 1'b1);
    chk("lshift_held", 32'(mod_state), 32'h1);
    send(8'h1C); send(8'hF0); send(8'h12); idle(1, 1'b1);
    chk("lshift_released", 32'(mod_state), 32'h0);
    idle(3, 1'b1);

    // pause sequence
    p0 = n_pop;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(4, 1'b1);
    chk("pause_events", 32'(n_pop - p0), 32'd1);
    chk("pause_mods", 32'(mod_state), 32'h0);

    // overflow: depth+1 makes with consumer stalled
    o0 = seen_ovf; p0 = n_pop;
    step(1'b1, 8'h1C, 1'b0); step(1'b1, 8'h32, 1'b0); step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h23, 1'b0); step(1'b1, 8'h24, 1'b0);
    idle(4, 1'b0);
    chk("ovf_pulses", 32'(seen_ovf - o0), 32'd1);
    chk("ovf_head", 32'(key_code), 32'h1C);
    idle(8, 1'b1);
    chk("ovf_kept", 32'(n_pop - p0), 32'd4);

    // prefix timeout then recovery
    e0 = seen_err; p0 = n_pop;
    send(8'hE0); idle(TO + 5, 1'b1);
    chk("timeout_err", 32'(seen_err - e0), 32'd1);
    send(8'h1C); idle(4, 1'b1);
    chk("timeout_recover", 32'(n_pop - p0), 32'd1);

    // error byte
    e0 = seen_err; p0 = n_pop;
    send(8'hFF); idle(3, 1'b1);
    chk("ff_err", 32'(seen_err - e0), 32'd1);
    chk("ff_noevent", 32'(n_pop - p0), 32'd0);

    // reset mid-sequence with FIFO occupied
    step(1'b1, 8'h1C, 1'b0); step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0);
    do_reset();
    p0 = n_pop;
    send(8'h1C); idle(4, 1'b1);
    chk("post_reset_event", 32'(n_pop - p0), 32'd1);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) idle(TO + 2, 1'b1);
      else step($urandom_range(0, 2) != 0, pick_byte(), $urandom_range(0, 3) != 0);
    end
    idle(TO + 10, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("total_ovf", 32'(seen_ovf), 32'(m_drops));
    chk("total_seq_err", 32'(seen_err), 32'(m_errs));
    chk("final_mods", 32'(mod_state), 32'(m_mods));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
